// File: rtl/act_quant_writeback_if.sv
// Bus bundles for act_quant_writeback: accumulated-result stream in, packed-word write port out.
interface acc_stream_if #(
  parameter int ACC_WIDTH = 32
);
  logic                 in_valid;
  logic [ACC_WIDTH-1:0] in_data;
  logic                 in_last;
  logic                 in_ready;

  modport master (output in_valid, in_data, in_last, input in_ready);
  modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

interface mem_wr_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int ADDR_WIDTH = 12
);
  logic                       wr_valid;
  logic                       wr_ready;
  logic [ADDR_WIDTH-1:0]      wr_addr;
  logic [PACK*DATA_WIDTH-1:0] wr_data;
  logic [PACK-1:0]            wr_mask;

  modport master (output wr_valid, wr_addr, wr_data, wr_mask, input wr_ready);
  modport slave  (input wr_valid, wr_addr, wr_data, wr_mask, output wr_ready);
endinterface

// File: rtl/act_quant_writeback.sv
// Quantises accumulator results (ReLU, rounding shift, saturation), packs them into
// memory words and streams the words to the feature-map buffer at consecutive addresses.
module act_quant_writeback #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int PACK       = 4,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [4:0]            shift,
  input  logic                  relu_en,
  acc_stream_if.slave           acc,
  mem_wr_if.master              wr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] word_count
);

  localparam int IDX_W  = $clog2(PACK);
  localparam int WORD_W = PACK * DATA_WIDTH;

  localparam logic signed [ACC_WIDTH:0] UMAX = (ACC_WIDTH+1)'((1 << DATA_WIDTH) - 1);
  localparam logic signed [ACC_WIDTH:0] SMAX = (ACC_WIDTH+1)'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // One extra bit of headroom keeps the rounding add from wrapping at the positive limit.
  function automatic logic signed [ACC_WIDTH:0] round_shift(
    input logic signed [ACC_WIDTH-1:0] d,
    input logic [4:0]                  sh
  );
    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] rnd;
    ext = {d[ACC_WIDTH-1], d};
    rnd = '0;
    if (sh != 5'd0) rnd = (ACC_WIDTH+1)'(1) << (sh - 5'd1);
    return (ext + rnd) >>> sh;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] saturate(
    input logic signed [ACC_WIDTH:0] v,
    input logic                      relu
  );
    if (relu) begin
      if (v < 0)         return '0;
      else if (v > UMAX) return '1;
      else               return v[DATA_WIDTH-1:0];
    end else begin
      if (v > SMAX)      return SMAX[DATA_WIDTH-1:0];
      else if (v < SMIN) return SMIN[DATA_WIDTH-1:0];
      else               return v[DATA_WIDTH-1:0];
    end
  endfunction

  state_t                state_q, state_d;
  logic [4:0]            shift_q, shift_d;
  logic                  relu_q, relu_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WORD_W-1:0]     lanes_q, lanes_d;
  logic [PACK-1:0]       lmask_q, lmask_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0]     wr_data_q, wr_data_d;
  logic [PACK-1:0]       wr_mask_q, wr_mask_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic                  in_ready;
  logic                  accept;
  logic                  wr_fire;
  logic [DATA_WIDTH-1:0] q_elem;
  logic [WORD_W-1:0]     new_lanes;
  logic [PACK-1:0]       new_mask;

  assign in_ready = (state_q == RUN) && (!wr_valid_q || wr.wr_ready);
  assign accept   = acc.in_valid && in_ready;
  assign wr_fire  = wr_valid_q && wr.wr_ready;
  assign q_elem   = (relu_q && acc.in_data[ACC_WIDTH-1]) ? '0
                  : saturate(round_shift(acc.in_data, shift_q), relu_q);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    relu_d     = relu_q;
    idx_d      = idx_q;
    lanes_d    = lanes_q;
    lmask_d    = lmask_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_mask_d  = wr_mask_q;
    cnt_d      = cnt_q;

    new_lanes = lanes_q;
    new_lanes[idx_q*DATA_WIDTH +: DATA_WIDTH] = q_elem;
    new_mask  = lmask_q | (PACK'(1) << idx_q);

    if (wr_fire) begin
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q + 1'b1;
      cnt_d      = cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          wr_addr_d = base_addr;
          shift_d   = shift;
          relu_d    = relu_en;
          cnt_d     = '0;
          idx_d     = '0;
          lanes_d   = '0;
          lmask_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          // A completing beat reloads the output word even as the previous one is taken.
          if ((idx_q == IDX_W'(PACK - 1)) || acc.in_last) begin
            wr_data_d  = new_lanes;
            wr_mask_d  = new_mask;
            wr_valid_d = 1'b1;
            idx_d      = '0;
            lanes_d    = '0;
            lmask_d    = '0;
          end else begin
            lanes_d = new_lanes;
            lmask_d = new_mask;
            idx_d   = idx_q + 1'b1;
          end
          if (acc.in_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (wr_fire) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      idx_q      <= '0;
      lanes_q    <= '0;
      lmask_q    <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_mask_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      relu_q     <= relu_d;
      idx_q      <= idx_d;
      lanes_q    <= lanes_d;
      lmask_q    <= lmask_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_mask_q  <= wr_mask_d;
      cnt_q      <= cnt_d;
    end
  end

  assign acc.in_ready = in_ready;
  assign wr.wr_valid  = wr_valid_q;
  assign wr.wr_addr   = wr_addr_q;
  assign wr.wr_data   = wr_data_q;
  assign wr.wr_mask   = wr_mask_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign word_count   = cnt_q;

endmodule

// File: doc/act_quant_writeback.md
Name: act_quant_writeback

Overview:
- Downstream of the accumulator stage; consumes one accumulated ACC_WIDTH result per strobe (conv pixel or FC neuron).
- Applies optional ReLU, rounding arithmetic right shift and saturation to DATA_WIDTH.
- Packs PACK results per memory word and writes them to the feature-map buffer through a valid/ready write port with an auto-incrementing address.
- Signals layer completion.

Parameters:
- DATA_WIDTH, 8, output element width.
- ACC_WIDTH, 32, accumulated input width (matches BIAS_WIDTH).
- PACK, 4, elements per write word (power of 2, >=2).
- ADDR_WIDTH, 12, write address width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse; latches cfg, enters RUN.
- base_addr  input  ADDR_WIDTH  first write address, latched on start.
- shift  input  5  right-shift amount, latched on start.
- relu_en  input  1  ReLU plus unsigned saturation when 1, latched on start.
- in_valid  input  1  accumulated result valid.
- in_data  input  ACC_WIDTH  accumulated result, two's complement.
- in_last  input  1  final result of the layer, qualified by in_valid.
- in_ready  output  1  result accepted when in_valid && in_ready.
- wr_valid  output  1  write word valid.
- wr_ready  input  1  memory accepts word.
- wr_addr  output  ADDR_WIDTH  word address.
- wr_data  output  PACK*DATA_WIDTH  lane 0 in LSBs.
- wr_mask  output  PACK  per-lane write enable.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse after last word accepted.
- word_count  output  ADDR_WIDTH  words accepted since start.

Behaviour:
- Reset (sync, any state, including mid-operation): state IDLE; in_ready=0, wr_valid=0, wr_addr=0, wr_data=0, wr_mask=0, busy=0, done=0, word_count=0; lane index 0; pack lanes 0. A pending word is discarded.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start. Latches base_addr into wr_addr, plus shift and relu_en; clears word_count and lane index.
  - RUN -> DRAIN on accepting a beat with in_last=1.
  - DRAIN -> DONE when wr_valid && wr_ready.
  - DONE: done=1 for exactly one cycle -> IDLE.
  - start in any state other than IDLE is ignored.
- in_ready = (state==RUN) && (!wr_valid || wr_ready). in_valid is ignored when in_ready=0.
- Quantisation, combinational on accepted beat:
  - If relu_en and in_data<0: x=0.
  - Else x = (in_data + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, computed in ACC_WIDTH+1 bits so the rounding add cannot wrap.
  - Saturate: relu_en=1 -> [0, 2^DATA_WIDTH-1]; relu_en=0 -> [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Packing: an accepted beat writes lane[idx] and idx increments.
  - If idx==PACK-1 or in_last, at that same edge: wr_data <= lanes including the new element; wr_mask <= lanes written since the last flush; wr_valid <= 1; idx <= 0; lanes cleared to 0.
  - Latency: a completing beat accepted at edge t gives wr_valid=1 after edge t.
  - A partial final word has unwritten lanes = 0 and their mask bits = 0.
- Write handshake:
  - wr_data, wr_mask and wr_addr hold stable while wr_valid && !wr_ready.
  - On wr_valid && wr_ready: wr_addr+1, wrapping modulo 2^ADDR_WIDTH; word_count+1.
  - wr_valid clears unless a new word completes in the same cycle, in which case wr_valid stays 1 and the new word loads (back-to-back, no bubble).
- Stall: while wr_valid && !wr_ready, in_ready=0; lane contents are preserved.
- in_last on the very first beat: single-lane word, mask 0b0001.

Test Plan:
- relu_en=0, shift=0, base_addr=0x010, 8 beats 1..8, last on beat 8, wr_ready=1 -> words 0x04030201 @0x010 and 0x08070605 @0x011, mask 0xF, done one cycle after second write, word_count=2.
- relu_en=1, shift=4, inputs 24, -50, 4095, 7 (last) -> lanes 2, 0, 255 (saturated), 0 (7+8=15>>4=0); word 0x00FF0002, mask 0xF.
- relu_en=0, shift=2, inputs -6, 1000, -1000, 5 (last) -> -1 (0xFF), 127, -128 (0x80), 1 (5+2=7>>2=1); word 0x0180 7FFF.
- 6 beats with last on beat 6 -> second word has mask 0x3, upper lanes 0, wr_addr=base+1.
- wr_ready held 0 for 5 cycles with a word pending -> in_ready=0, wr_data/wr_addr stable; release -> accepted once, no duplicate, no lost beat.
- rst asserted mid-RUN with a partial word pending -> next cycle all outputs at reset values; a new start with base_addr=0x000 writes from 0x000.
